keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/keypad_debounce_cell.sv | 50 +++++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 tb/tb_keypad_scanner.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, scan FSM state type and key-code helper for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic {
        DRIVE = 1'b0,
        EVAL  = 1'b1
    } scan_state_e;

    // Key code is {row, col}, so codes within one column step by 4.
    function automatic logic [KEY_W-1:0] make_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Debounced key report bundle: live pressed map plus a one-cycle press event with its code.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_KEYS-1:0] key_state;
    logic                key_valid;
    logic [KEY_W-1:0]    key_code;

    modport master (
        output key_state,
        output key_valid,
        output key_code
    );

    modport slave (
        input key_state,
        input key_valid,
        input key_code
    );

endinterface

// File: rtl/keypad_debounce_cell.sv
// One key's debounce: a sample must disagree with the debounced bit for
// DEBOUNCE_SCANS consecutive enabled cycles before the bit follows it.
module keypad_debounce_cell #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic sample,
    output logic state,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       state_q;
    logic       state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise    = 1'b0;
        if (en) begin
            if (sample == state_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = sample;
                cnt_d   = 4'd0;
                rise    = sample;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= 4'd0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: strobes one column low, snapshots the synchronized rows,
// then spends four cycles feeding that column's keys through their debounce cells.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic [NUM_COLS-1:0]    COL,
    input  logic [NUM_ROWS-1:0]    ROW,
    keypad_scanner_if.master       key_if
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;

    scan_state_e         state_q;
    scan_state_e         state_d;
    logic [SET_W-1:0]    settle_q;
    logic [SET_W-1:0]    settle_d;
    logic [1:0]          col_idx_q;
    logic [1:0]          col_idx_d;
    logic [1:0]          row_idx_q;
    logic [1:0]          row_idx_d;
    logic [NUM_ROWS-1:0] snap_q;
    logic [NUM_ROWS-1:0] snap_d;
    logic                key_valid_q;
    logic                key_valid_d;
    logic [KEY_W-1:0]    key_code_q;
    logic [KEY_W-1:0]    key_code_d;

    logic [KEY_W-1:0]    sel_code;
    logic                sel_sample;
    logic [NUM_KEYS-1:0] cell_en;
    logic [NUM_KEYS-1:0] cell_rise;
    logic [NUM_KEYS-1:0] cell_state;
    logic                any_rise;

    // ROW is asynchronous to CLK; idle (released) level is all ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
        end
    end

    assign sel_code   = make_code(row_idx_q, col_idx_q);
    assign sel_sample = snap_q[row_idx_q];
    assign any_rise   = |cell_rise;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        snap_d      = snap_q;
        key_valid_d = any_rise;
        key_code_d  = any_rise ? sel_code : key_code_q;
        case (state_q)
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    snap_d    = ~row_sync_q;
                    row_idx_d = 2'd0;
                    state_d   = EVAL;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            EVAL: begin
                row_idx_d = row_idx_q + 2'd1;
                if (row_idx_q == 2'd3) begin
                    col_idx_d = col_idx_q + 2'd1;
                    settle_d  = '0;
                    state_d   = DRIVE;
                end
            end
            default: begin
                state_d = DRIVE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= DRIVE;
            settle_q    <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            snap_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            snap_q      <= snap_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    // Decoded from one index, so exactly one strobe is low outside reset.
    assign COL = RST ? 4'b1111 : ~(4'b0001 << col_idx_q);

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_cell
            assign cell_en[gi] = (state_q == EVAL) && (sel_code == KEY_W'(gi));

            keypad_debounce_cell #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_cell (
                .CLK   (CLK),
                .RST   (RST),
                .en    (cell_en[gi]),
                .sample(sel_sample),
                .state (cell_state[gi]),
                .rise  (cell_rise[gi])
            );
        end
    endgenerate

    assign key_if.key_state = cell_state;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-matrix model on COL/ROW.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int SCAN   = 4 * (SETTLE + 4);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       col;
    logic [3:0]       row;
    logic [3:0][3:0]  keys;   // keys[r][c] = 1 means key (r,c) closed

    keypad_scanner_if kif();

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .COL   (col),
        .ROW   (row),
        .key_if(kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r] & ~col);
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    logic [3:0] pulse_q[$];
    int         col_viol       = 0;
    int         rst_valid_viol = 0;
    int         dbl_viol       = 0;
    logic       prev_valid     = 1'b0;
    logic [3:0] prev_code      = 4'h0;
    logic       prev_rst       = 1'b1;

    always @(negedge clk) begin
        if ($countones(~col) > 1) col_viol++;
        if (kif.key_valid && (rst || prev_rst)) rst_valid_viol++;
        if (kif.key_valid && prev_valid && (kif.key_code == prev_code)) dbl_viol++;
        if (kif.key_valid) pulse_q.push_back(kif.key_code);
        prev_valid = kif.key_valid;
        prev_code  = kif.key_code;
        prev_rst   = rst;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the first cycle of the column-0 strobe.
    task automatic wait_scan_start();
        logic [3:0] last;
        logic       found;
        found = 1'b0;
        last  = col;
        for (int i = 0; i < 4 * SCAN; i++) begin
            tick(1);
            if (col == 4'b1110 && last == 4'b0111) begin
                found = 1'b1;
                break;
            end
            last = col;
        end
        check_vec("scan_align_found", {31'd0, found}, 32'd1);
    endtask

    task automatic check_pulses(input string tag, input int n_exp, input logic [3:0] c0,
                                input logic [3:0] c1, input logic [3:0] c2);
        logic [3:0] exp_codes [3];
        exp_codes[0] = c0;
        exp_codes[1] = c1;
        exp_codes[2] = c2;
        check_vec({tag, "_count"}, pulse_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < pulse_q.size(); i++) begin
            check_vec($sformatf("%s_code%0d", tag, i), {28'd0, pulse_q[i]}, {28'd0, exp_codes[i]});
        end
    endtask

    initial begin
        logic [3:0] exp_col;
        keys = '0;

        // 1. reset and idle scanning
        tick(5);
        @(negedge clk);
        check_vec("rst_col", col, 4'b1111);
        check_vec("rst_state", kif.key_state, 16'h0000);
        check_vec("rst_valid", kif.key_valid, 1'b0);
        check_vec("rst_code", kif.key_code, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k <= SCAN; k++) begin
            @(negedge clk);
            exp_col = 4'b1111 ^ (4'b0001 << ((k % SCAN) / 12));
            if ((k % 12 == 0) || (k % 12 == 11))
                check_vec($sformatf("idle_col_k%0d", k), col, exp_col);
        end
        tick(1);
        pulse_q.delete();
        tick(10 * SCAN);
        check_pulses("idle_pulses", 0, 4'h0, 4'h0, 4'h0);
        check_vec("idle_state", kif.key_state, 16'h0000);

        // 2. single press of (2,1), then release
        keys[2][1] = 1'b1;
        pulse_q.delete();
        tick(2 * SCAN);
        check_vec("press_early_state", kif.key_state, 16'h0000);
        tick(2 * SCAN + 20);
        check_pulses("press", 1, 4'h9, 4'h0, 4'h0);
        check_vec("press_state", kif.key_state, 16'h0200);
        keys[2][1] = 1'b0;
        pulse_q.delete();
        tick(2 * SCAN);
        check_vec("release_early_state", kif.key_state, 16'h0200);
        tick(2 * SCAN + 20);
        check_pulses("release", 0, 4'h0, 4'h0, 4'h0);
        check_vec("release_state", kif.key_state, 16'h0000);
        check_vec("release_code_held", kif.key_code, 4'h9);

        // 3. bounce rejection on (0,0)
        pulse_q.delete();
        for (int rep = 0; rep < 5; rep++) begin
            keys[0][0] = 1'b1;
            tick(SCAN);
            keys[0][0] = 1'b0;
            tick(SCAN);
            keys[0][0] = 1'b1;
            tick(SCAN);
        end
        keys[0][0] = 1'b0;
        tick(4 * SCAN);
        check_pulses("bounce", 0, 4'h0, 4'h0, 4'h0);
        check_vec("bounce_state", kif.key_state, 16'h0000);

        // 4. three simultaneous presses aligned to a scan start
        wait_scan_start();
        keys[0][3] = 1'b1;
        keys[3][3] = 1'b1;
        keys[1][0] = 1'b1;
        pulse_q.delete();
        tick(4 * SCAN + 20);
        check_pulses("multi", 3, 4'h4, 4'h3, 4'hF);
        check_vec("multi_state", kif.key_state, 16'h8018);
        keys = '0;
        pulse_q.delete();
        tick(4 * SCAN + 20);
        check_pulses("multi_release", 0, 4'h0, 4'h0, 4'h0);
        check_vec("multi_release_state", kif.key_state, 16'h0000);

        // 5. reset during an EVAL cycle with (1,2) held
        keys[1][2] = 1'b1;
        pulse_q.delete();
        tick(4 * SCAN + 20);
        check_pulses("hold", 1, 4'h6, 4'h0, 4'h0);
        check_vec("hold_state", kif.key_state, 16'h0040);
        wait_scan_start();
        tick(SETTLE + 1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("midrst_col", col, 4'b1111);
        tick(1);
        check_vec("midrst_state", kif.key_state, 16'h0000);
        check_vec("midrst_valid", kif.key_valid, 1'b0);
        rst = 1'b0;
        pulse_q.delete();
        @(negedge clk);
        check_vec("midrst_col_after", col, 4'b1110);
        tick(4 * SCAN + 20);
        check_pulses("redetect", 1, 4'h6, 4'h0, 4'h0);
        check_vec("redetect_state", kif.key_state, 16'h0040);
        keys = '0;
        tick(4 * SCAN);

        // 6. invariants watched over the whole run
        check_vec("col_exclusive", col_viol, 0);
        check_vec("valid_near_rst", rst_valid_viol, 0);
        check_vec("double_pulse", dbl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
